// File: rtl/ctrl_layer_seq_pkg.sv
// Shared types and constants for the layer-parameter sequencer.
// The descriptor holds terminal counts (count-1), so outputs can be driven without arithmetic.
package ctrl_layer_seq_pkg;

  // Array geometry of the NPU datapath.
  localparam int K           = 5;
  localparam int W           = 32;
  localparam int C1_NB_TILE  = 6;
  localparam int C1_NB_TILEB = 1;
  localparam int C1_NB_TILEC = 6;
  localparam int C2_NB_TILE  = 3;
  localparam int C2_NB_TILEB = 6;
  localparam int C2_NB_TILEC = 16;

  // Field widths of the terminal-count outputs.
  localparam int CLOG2K = $clog2(K);
  localparam int CLOG2W = $clog2(W);
  localparam int CLOG2T = 3;
  localparam int CLOG2B = 3;
  localparam int CLOG2C = 4;

  typedef struct packed {
    logic              opcode;
    logic              last;
    logic [CLOG2K-1:0] ksize;
    logic [CLOG2W-1:0] ckgate;
    logic [CLOG2T-1:0] i_tile;
    logic [CLOG2T-1:0] o_tile;
    logic [CLOG2B-1:0] ifmaps;
    logic [CLOG2C-1:0] ofmaps;
  } arv_desc_t;

  localparam int DESC_W = $bits(arv_desc_t);

  // The two layers of the original fixed network; C1 uses opcode 0, C2 opcode 1 and closes the sequence.
  localparam arv_desc_t ARV_DESC_C1 = '{
    opcode: 1'b0,
    last:   1'b0,
    ksize:  CLOG2K'(K - 1),
    ckgate: CLOG2W'(W - K),
    i_tile: CLOG2T'(C1_NB_TILE - 1),
    o_tile: CLOG2T'(C1_NB_TILE - 1),
    ifmaps: CLOG2B'(C1_NB_TILEB - 1),
    ofmaps: CLOG2C'(C1_NB_TILEC - 1)
  };

  localparam arv_desc_t ARV_DESC_C2 = '{
    opcode: 1'b1,
    last:   1'b1,
    ksize:  CLOG2K'(K - 1),
    ckgate: CLOG2W'(1),
    i_tile: CLOG2T'(C2_NB_TILE - 1),
    o_tile: CLOG2T'(C2_NB_TILE - 1),
    ifmaps: CLOG2B'(C2_NB_TILEB - 1),
    ofmaps: CLOG2C'(C2_NB_TILEC - 1)
  };

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_ISSUE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/ctrl_layer_seq_if.sv
// Configuration, control and layer-parameter bus between the NPU controller and the sequencer.
// The master is the controller side; the slave is the sequencer.
interface ctrl_layer_seq_if #(parameter int NLAYER = 4);
  import ctrl_layer_seq_pkg::*;

  localparam int CLOG2L = $clog2(NLAYER);

  logic              cfg_we;
  logic [CLOG2L-1:0] cfg_addr;
  logic [DESC_W-1:0] cfg_wdata;
  logic              cfg_err;
  logic              start;
  logic              abort;
  logic              prm_valid;
  logic              prm_ready;
  logic              layer_done;
  logic              opcode;
  logic [CLOG2K-1:0] arv_ksize;
  logic [CLOG2W-1:0] arv_ckgate;
  logic [CLOG2T-1:0] arv_i_tile;
  logic [CLOG2T-1:0] arv_o_tile;
  logic [CLOG2B-1:0] arv_ifmaps;
  logic [CLOG2C-1:0] arv_ofmaps;
  logic [CLOG2L-1:0] layer_idx;
  logic              busy;
  logic              done;
  logic              seq_err;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, abort, prm_ready, layer_done,
    input  cfg_err, prm_valid, opcode, arv_ksize, arv_ckgate, arv_i_tile, arv_o_tile,
           arv_ifmaps, arv_ofmaps, layer_idx, busy, done, seq_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, abort, prm_ready, layer_done,
    output cfg_err, prm_valid, opcode, arv_ksize, arv_ckgate, arv_i_tile, arv_o_tile,
           arv_ifmaps, arv_ofmaps, layer_idx, busy, done, seq_err
  );

endinterface

// File: rtl/ctrl_layer_seq_tbl.sv
// Descriptor table: NLAYER flopped slots, one synchronous write port and one
// combinational read port. Reset restores the C1/C2 network in slots 0 and 1.
module ctrl_layer_tbl
  import ctrl_layer_seq_pkg::*;
#(
  parameter int NLAYER = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(NLAYER)-1:0]  waddr,
  input  arv_desc_t                  wdata,
  input  logic [$clog2(NLAYER)-1:0]  raddr,
  output arv_desc_t                  rdata
);

  arv_desc_t mem [NLAYER];

  // Slot storage: defaults on reset, otherwise take accepted writes to existing slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLAYER; i++) begin
        mem[i] <= '0;
      end
      mem[0] <= ARV_DESC_C1;
      mem[1] <= ARV_DESC_C2;
    end else if (we && (int'(waddr) < NLAYER)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_layer_seq.sv
// Layer-parameter sequencer: walks the descriptor table from slot 0, issuing one
// layer per valid/ready handshake and advancing on layer_done until a descriptor
// marked last (or the final slot) completes.
module ctrl_layer_seq
  import ctrl_layer_seq_pkg::*;
#(
  parameter int NLAYER = 4
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_layer_seq_if.slave  bus
);

  localparam int CLOG2L = $clog2(NLAYER);
  localparam logic [CLOG2L-1:0] LAST_IDX = CLOG2L'(NLAYER - 1);

  seq_state_t        state;
  seq_state_t        state_next;
  logic [CLOG2L-1:0] idx;
  logic [CLOG2L-1:0] idx_next;
  arv_desc_t         rd_desc;
  arv_desc_t         cur_desc;
  logic              cfg_accept;
  logic              start_accept;
  logic              cfg_err;
  logic              seq_err;

  // Table writes are only safe while no sequence is reading the table.
  assign cfg_accept   = bus.cfg_we && (state == SEQ_IDLE);
  assign start_accept = bus.start && !bus.abort && (state == SEQ_IDLE);

  ctrl_layer_tbl #(
    .NLAYER (NLAYER)
  ) u_tbl (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_accept),
    .waddr (bus.cfg_addr),
    .wdata (arv_desc_t'(bus.cfg_wdata)),
    .raddr (idx),
    .rdata (rd_desc)
  );

  // Next-state and slot-index decode; abort overrides everything and IDLE always restarts at slot 0.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      SEQ_IDLE:  if (bus.start) state_next = SEQ_LOAD;
      SEQ_LOAD:  state_next = SEQ_ISSUE;
      SEQ_ISSUE: if (bus.prm_ready) state_next = SEQ_RUN;
      SEQ_RUN: begin
        if (bus.layer_done) begin
          if (cur_desc.last || (idx == LAST_IDX)) begin
            state_next = SEQ_DONE;
          end else begin
            state_next = SEQ_LOAD;
            idx_next   = idx + CLOG2L'(1);
          end
        end
      end
      SEQ_DONE:  state_next = SEQ_IDLE;
      default:   state_next = SEQ_IDLE;
    endcase
    if (bus.abort) begin
      state_next = SEQ_IDLE;
    end
    if (state_next == SEQ_IDLE) begin
      idx_next = '0;
    end
  end

  // State and slot-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEQ_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Output descriptor register: captured in LOAD, then held until the next LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_desc <= '0;
    end else if (state == SEQ_LOAD) begin
      cur_desc <= rd_desc;
    end
  end

  // Error flags: cfg_err pulses for a rejected write, seq_err sticks until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      cfg_err <= bus.cfg_we && (state != SEQ_IDLE);
      if (bus.layer_done && (state != SEQ_RUN)) begin
        seq_err <= 1'b1;
      end else if (start_accept) begin
        seq_err <= 1'b0;
      end
    end
  end

  assign bus.prm_valid  = (state == SEQ_ISSUE);
  assign bus.busy       = (state != SEQ_IDLE);
  assign bus.done       = (state == SEQ_DONE);
  assign bus.layer_idx  = idx;
  assign bus.opcode     = cur_desc.opcode;
  assign bus.arv_ksize  = cur_desc.ksize;
  assign bus.arv_ckgate = cur_desc.ckgate;
  assign bus.arv_i_tile = cur_desc.i_tile;
  assign bus.arv_o_tile = cur_desc.o_tile;
  assign bus.arv_ifmaps = cur_desc.ifmaps;
  assign bus.arv_ofmaps = cur_desc.ofmaps;
  assign bus.cfg_err    = cfg_err;
  assign bus.seq_err    = seq_err;

endmodule

// File: tb/tb_ctrl_layer_seq.sv
// Directed bench for the layer sequencer: default C1/C2 run, programmed 4-layer run
// with a stalled handshake, rejected writes, abort, seq_err, wrap and mid-run reset.
module tb_ctrl_layer_seq;
  import ctrl_layer_seq_pkg::*;

  localparam int NLAYER = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ctrl_layer_seq_if #(.NLAYER(NLAYER)) bus();

  ctrl_layer_seq #(.NLAYER(NLAYER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hand-computed descriptors: C1 = {K-1=4, W-K=27, tile 5, ifmaps 0, ofmaps 5}, C2 = {4, 1, 2, 5, 15}.
  localparam arv_desc_t EXP_C1 = '{opcode:1'b0, last:1'b0, ksize:3'd4, ckgate:5'd27,
                                   i_tile:3'd5, o_tile:3'd5, ifmaps:3'd0, ofmaps:4'd5};
  localparam arv_desc_t EXP_C2 = '{opcode:1'b1, last:1'b1, ksize:3'd4, ckgate:5'd1,
                                   i_tile:3'd2, o_tile:3'd2, ifmaps:3'd5, ofmaps:4'd15};
  localparam arv_desc_t D0  = '{opcode:1'b1, last:1'b0, ksize:3'd1, ckgate:5'd2,
                                i_tile:3'd3, o_tile:3'd4, ifmaps:3'd1, ofmaps:4'd6};
  localparam arv_desc_t D1  = '{opcode:1'b0, last:1'b0, ksize:3'd2, ckgate:5'd10,
                                i_tile:3'd1, o_tile:3'd0, ifmaps:3'd3, ofmaps:4'd9};
  localparam arv_desc_t D2  = '{opcode:1'b1, last:1'b0, ksize:3'd3, ckgate:5'd31,
                                i_tile:3'd7, o_tile:3'd7, ifmaps:3'd7, ofmaps:4'd15};
  localparam arv_desc_t D3  = '{opcode:1'b0, last:1'b1, ksize:3'd0, ckgate:5'd0,
                                i_tile:3'd2, o_tile:3'd6, ifmaps:3'd2, ofmaps:4'd5};
  localparam arv_desc_t D3W = '{opcode:1'b1, last:1'b0, ksize:3'd6, ckgate:5'd17,
                                i_tile:3'd4, o_tile:3'd1, ifmaps:3'd6, ofmaps:4'd3};
  localparam arv_desc_t JUNK = '{opcode:1'b0, last:1'b1, ksize:3'd7, ckgate:5'd7,
                                 i_tile:3'd0, o_tile:3'd0, ifmaps:3'd0, ofmaps:4'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic rdy, input logic ld);
    bus.start      = st;
    bus.abort      = ab;
    bus.prm_ready  = rdy;
    bus.layer_done = ld;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input arv_desc_t d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = d;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic check_fields(input string tag, input arv_desc_t e, input int idx);
    checkOutput({tag, ".valid"},  32'(bus.prm_valid),  32'd1);
    checkOutput({tag, ".idx"},    32'(bus.layer_idx),  32'(idx));
    checkOutput({tag, ".opcode"}, 32'(bus.opcode),     32'(e.opcode));
    checkOutput({tag, ".ksize"},  32'(bus.arv_ksize),  32'(e.ksize));
    checkOutput({tag, ".ckgate"}, 32'(bus.arv_ckgate), 32'(e.ckgate));
    checkOutput({tag, ".i_tile"}, 32'(bus.arv_i_tile), 32'(e.i_tile));
    checkOutput({tag, ".o_tile"}, 32'(bus.arv_o_tile), 32'(e.o_tile));
    checkOutput({tag, ".ifmaps"}, 32'(bus.arv_ifmaps), 32'(e.ifmaps));
    checkOutput({tag, ".ofmaps"}, 32'(bus.arv_ofmaps), 32'(e.ofmaps));
  endtask

  // One layer: expects ISSUE exactly one step after the previous start/layer_done cycle.
  task automatic issue_layer(input string tag, input arv_desc_t e, input int idx,
                             input bit is_last, input int hold);
    step();
    check_fields(tag, e, idx);
    for (int i = 0; i < hold; i++) begin
      step();
      checkOutput({tag, ".hold_valid"}, 32'(bus.prm_valid), 32'd1);
    end
    if (hold > 0) check_fields({tag, ".held"}, e, idx);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, ".run_valid"}, 32'(bus.prm_valid), 32'd0);
    checkOutput({tag, ".run_busy"},  32'(bus.busy),      32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    if (is_last) begin
      checkOutput({tag, ".done"},       32'(bus.done),       32'd1);
      step();
      checkOutput({tag, ".done_gone"},  32'(bus.done),       32'd0);
      checkOutput({tag, ".idle_busy"},  32'(bus.busy),       32'd0);
      checkOutput({tag, ".idle_idx"},   32'(bus.layer_idx),  32'd0);
      checkOutput({tag, ".idle_ofm"},   32'(bus.arv_ofmaps), 32'(e.ofmaps));
      checkOutput({tag, ".idle_ckg"},   32'(bus.arv_ckgate), 32'(e.ckgate));
    end else begin
      checkOutput({tag, ".no_done"},    32'(bus.done),       32'd0);
      checkOutput({tag, ".load_valid"}, 32'(bus.prm_valid),  32'd0);
    end
  endtask

  // Bound on total run time in case the design never reaches a checked state.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    $display("[TB] reset state");
    checkOutput("rst.valid",   32'(bus.prm_valid),  32'd0);
    checkOutput("rst.busy",    32'(bus.busy),       32'd0);
    checkOutput("rst.done",    32'(bus.done),       32'd0);
    checkOutput("rst.idx",     32'(bus.layer_idx),  32'd0);
    checkOutput("rst.ksize",   32'(bus.arv_ksize),  32'd0);
    checkOutput("rst.seq_err", 32'(bus.seq_err),    32'd0);
    checkOutput("rst.cfg_err", 32'(bus.cfg_err),    32'd0);
    rst = 1'b0;

    $display("[TB] default two-layer sequence");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("def.load_valid", 32'(bus.prm_valid), 32'd0);
    checkOutput("def.load_busy",  32'(bus.busy),      32'd1);
    issue_layer("def.c1", EXP_C1, 0, 1'b0, 0);
    issue_layer("def.c2", EXP_C2, 1, 1'b1, 0);

    $display("[TB] programmed four-layer sequence");
    cfg_write(2'd0, D0);
    checkOutput("prog.cfg_err0", 32'(bus.cfg_err), 32'd0);
    cfg_write(2'd1, D1);
    cfg_write(2'd2, D2);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 2'd3;
    bus.cfg_wdata = D3;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    bus.cfg_we = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("prog.cfg_err_start", 32'(bus.cfg_err), 32'd0);
    issue_layer("prog.l0", D0, 0, 1'b0, 0);
    issue_layer("prog.l1", D1, 1, 1'b0, 10);
    issue_layer("prog.l2", D2, 2, 1'b0, 0);
    issue_layer("prog.l3", D3, 3, 1'b1, 0);

    $display("[TB] rejected write, ignored start, abort");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_fields("rej.l0", D0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 2'd0;
    bus.cfg_wdata = JUNK;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    bus.cfg_we = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rej.cfg_err",     32'(bus.cfg_err),   32'd1);
    checkOutput("rej.run_valid",   32'(bus.prm_valid), 32'd0);
    checkOutput("rej.run_idx",     32'(bus.layer_idx), 32'd0);
    step();
    checkOutput("rej.cfg_err_end", 32'(bus.cfg_err),   32'd0);
    checkOutput("rej.still_run",   32'(bus.prm_valid), 32'd0);
    checkOutput("rej.still_busy",  32'(bus.busy),      32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_fields("rej.l1", D1, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort.busy",    32'(bus.busy),      32'd0);
    checkOutput("abort.valid",   32'(bus.prm_valid), 32'd0);
    checkOutput("abort.idx",     32'(bus.layer_idx), 32'd0);
    checkOutput("abort.done",    32'(bus.done),      32'd0);
    checkOutput("abort.seq_err", 32'(bus.seq_err),   32'd0);
    step();
    checkOutput("abort.no_done", 32'(bus.done),      32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_fields("abort.restart", D0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort2.busy",  32'(bus.busy),      32'd0);
    checkOutput("abort2.valid", 32'(bus.prm_valid), 32'd0);

    $display("[TB] seq_err and wrap at final slot");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("serr.set",  32'(bus.seq_err), 32'd1);
    checkOutput("serr.busy", 32'(bus.busy),    32'd0);
    cfg_write(2'd3, D3W);
    step();
    checkOutput("serr.sticky", 32'(bus.seq_err), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("serr.cleared", 32'(bus.seq_err), 32'd0);
    issue_layer("wrap.l0", D0,  0, 1'b0, 0);
    issue_layer("wrap.l1", D1,  1, 1'b0, 0);
    issue_layer("wrap.l2", D2,  2, 1'b0, 0);
    issue_layer("wrap.l3", D3W, 3, 1'b1, 0);

    $display("[TB] reset during ISSUE");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("rst2.pre_valid", 32'(bus.prm_valid), 32'd1);
    rst = 1'b1;
    step();
    checkOutput("rst2.valid",  32'(bus.prm_valid),  32'd0);
    checkOutput("rst2.busy",   32'(bus.busy),       32'd0);
    checkOutput("rst2.idx",    32'(bus.layer_idx),  32'd0);
    checkOutput("rst2.opcode", 32'(bus.opcode),     32'd0);
    checkOutput("rst2.ksize",  32'(bus.arv_ksize),  32'd0);
    checkOutput("rst2.ckgate", 32'(bus.arv_ckgate), 32'd0);
    checkOutput("rst2.ofmaps", 32'(bus.arv_ofmaps), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    issue_layer("rst2.c1", EXP_C1, 0, 1'b0, 0);
    issue_layer("rst2.c2", EXP_C2, 1, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
